mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Arbitrates the single shared main-memory port between the I-cache and the D-cache. Each cache drives its own memory-control interface (MemRead/MemWrite, 16-bit address, write data, CacheBusy, CacheFinish). The arbiter grants memory to one cache at a time, forwards that cache's requests to the fixed-latency pipelined memory, and routes returning read data and its valid strobe back to the cache that issued the read. It sits between both caches and the memory model, directly downstream of the caches' memory-side ports.

## Interface
Parameters:
- MEM_LATENCY, 4: cycles from read issue to mem_data_valid; must be ≥ 1.

Ports (clock and reset first):
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- icache_MemRead  input  1  I-cache read request for one word
- icache_mem_addr  input  16  I-cache word address
- icache_CacheBusy  input  1  I-cache miss handling in progress
- icache_CacheFinish  input  1  I-cache fill complete (1-cycle pulse)
- dcache_MemRead  input  1  D-cache read request
- dcache_MemWrite  input  1  D-cache write request
- dcache_mem_addr  input  16  D-cache address
- dcache_mem_write_data  input  16  D-cache write data
- dcache_CacheBusy  input  1  D-cache miss or write in progress
- dcache_CacheFinish  input  1  D-cache operation complete (pulse)
- icache_grant / dcache_grant  output  1 each  memory currently owned by that cache
- icache_MemDataValid / dcache_MemDataValid  output  1 each  returned word valid for that cache
- icache_mem_read_data / dcache_mem_read_data  output  16 each  returned word, 0 when the matching valid is low
- mem_enable  output  1  memory access this cycle
- mem_wr  output  1  access is a write
- mem_addr  output  16  memory address
- mem_data_in  output  16  memory write data
- mem_data_out  input  16  memory read data
- mem_data_valid  input  1  mem_data_out is valid
- protocol_err  output  1  sticky error flag; cleared only by rst

## Operation
- States: IDLE, GRANT_I, GRANT_D, DRAIN. Reset: IDLE, last_owner=I, in-flight count 0, tag pipe empty, protocol_err 0. All outputs 0 in reset.
- IDLE transitions:
  - Only the D-cache requesting (CacheBusy or MemRead or MemWrite): go to GRANT_D.
  - Only the I-cache requesting: go to GRANT_I.
  - Both requesting: grant the cache that is not last_owner (first tie after reset goes to D).
- GRANT_x: grant output for x is 1. mem_enable, mem_addr and mem_wr follow x's MemRead/MemWrite combinationally. At most one access per cycle. The cache sequences its own word addresses.
- D-cache write: mem_enable=1, mem_wr=1, mem_data_in=dcache_mem_write_data. Writes are not tracked.
- dcache_MemRead and dcache_MemWrite both high: the write is issued, the read is dropped, and protocol_err is set.
- Each issued read pushes an owner tag into mem_tag_pipe.
- Release: owner's CacheFinish=1, or owner's CacheBusy=0 with no request that cycle. On release, last_owner is set to x. Next state is DRAIN if any read is still in flight after this cycle, otherwise IDLE.
- DRAIN: no grants and no issue. Go to IDLE in the cycle the in-flight count reaches 0.
- Return path: when mem_data_valid=1, the tag at the pipe's last stage selects the destination, and that cache's MemDataValid and read_data are driven combinationally.
- mem_data_valid=1 with an empty last stage: data is dropped and protocol_err is set.
- Requests from the non-owner are ignored. They are not queued; that cache holds its request until it sees its grant.

## Timing
- Request seen in IDLE in cycle t: grant asserted in t+1; the first access can issue in t+1.
- Read issued in cycle t: tag reaches the last stage in t+MEM_LATENCY, aligned with mem_data_valid. Routing adds 0 cycles.
- Back-to-back reads: one per cycle. Full 8-word fill: 8 issue cycles, last data returns MEM_LATENCY cycles after the last issue.
- At least one IDLE cycle separates two owners.
- In-flight counter: width $clog2(MEM_LATENCY+1). Increments on read issue, decrements on routed valid. Issue and return in the same cycle leave it unchanged. It never exceeds MEM_LATENCY.
- Reset mid-operation clears the tag pipe. Data returning afterwards is dropped and sets protocol_err only if it arrives after rst deasserts.

## Structure
- Package mem_arb_pkg: owner_t enum {OWN_I, OWN_D}, arb_state_t enum, and the default MEM_LATENCY constant.
- Sub-module mem_tag_pipe: MEM_LATENCY-deep shift register of {valid, owner_t}, with a push input and a last-stage output; asynchronous reset. The FSM and muxing live in mem_arbiter.

## Test plan
- I-cache-only fill: I reads addr 0,2,…,14 with data 1..8 returned at latency 4 → icache_MemDataValid for 8 cycles with data 1..8; dcache_MemDataValid stays 0; state returns to IDLE after the finish pulse.
- Simultaneous requests right after reset → dcache_grant in cycle t+1; I-cache is granted once the D fill finishes and drains; the next tie goes to D again.
- D-cache write addr 0x0040, data 0xBEEF → one cycle with mem_enable=1, mem_wr=1, mem_addr=0x0040, mem_data_in=0xBEEF; no tag pushed.
- D releases with 3 reads in flight → DRAIN for 3 cycles; I stays ungranted; the 3 returns route to dcache only.
- Spurious mem_data_valid while IDLE → no cache valid; protocol_err=1 and remains set.
- rst asserted mid-fill → all outputs 0 immediately; state IDLE; count 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared owner/state types and default memory latency for mem_arbiter
package mem_arb_pkg;
  typedef enum logic {OWN_I, OWN_D} owner_t;
  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, DRAIN} arb_state_t;
  localparam int MEM_LATENCY_DEF = 4;
endpackage

// File: rtl/mem_tag_pipe.sv
// mem_tag_pipe: DEPTH-stage shift register of {valid, owner} tags aligned with memory read latency
module mem_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = MEM_LATENCY_DEF
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push_i,
  input  owner_t owner_i,
  output logic   last_valid_o,
  output owner_t last_owner_o
);
  logic [DEPTH-1:0] vld_q, own_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      own_q <= '0;
    end else begin
      vld_q <= (vld_q << 1) | DEPTH'(push_i);
      own_q <= (own_q << 1) | DEPTH'(owner_i);
    end
  end
  assign last_valid_o = vld_q[DEPTH-1];
  assign last_owner_o = owner_t'(own_q[DEPTH-1]);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: grants the shared memory port to the I- or D-cache and routes read returns
// back to the cache that issued them.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LATENCY = MEM_LATENCY_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        icache_MemRead,
  input  logic [15:0] icache_mem_addr,
  input  logic        icache_CacheBusy,
  input  logic        icache_CacheFinish,
  input  logic        dcache_MemRead,
  input  logic        dcache_MemWrite,
  input  logic [15:0] dcache_mem_addr,
  input  logic [15:0] dcache_mem_write_data,
  input  logic        dcache_CacheBusy,
  input  logic        dcache_CacheFinish,
  output logic        icache_grant,
  output logic        dcache_grant,
  output logic        icache_MemDataValid,
  output logic        dcache_MemDataValid,
  output logic [15:0] icache_mem_read_data,
  output logic [15:0] dcache_mem_read_data,
  output logic        mem_enable,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data_in,
  input  logic [15:0] mem_data_out,
  input  logic        mem_data_valid,
  output logic        protocol_err
);
  localparam int CW = $clog2(MEM_LATENCY + 1);
  arb_state_t    state_q;
  owner_t        last_owner_q, tag_owner;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, i_req, d_req, issue, rel, tag_valid, routed;

  mem_tag_pipe #(.DEPTH(MEM_LATENCY)) u_tag_pipe (
    .clk         (clk),
    .rst         (rst),
    .push_i      (issue),
    .owner_i     (dcache_grant ? OWN_D : OWN_I),
    .last_valid_o(tag_valid),
    .last_owner_o(tag_owner)
  );

  always_comb begin
    i_req = icache_MemRead | icache_CacheBusy;
    d_req = dcache_MemRead | dcache_MemWrite | dcache_CacheBusy;
    icache_grant = state_q == GRANT_I;
    dcache_grant = state_q == GRANT_D;
    mem_wr = dcache_grant & dcache_MemWrite;
    mem_enable = (icache_grant & icache_MemRead) | (dcache_grant & (dcache_MemRead | dcache_MemWrite));
    // a write wins over a simultaneous read, so only pure reads are tagged
    issue = mem_enable & ~mem_wr;
    mem_addr = !mem_enable ? '0 : icache_grant ? icache_mem_addr : dcache_mem_addr;
    mem_data_in = mem_wr ? dcache_mem_write_data : '0;
    rel = (icache_grant & (icache_CacheFinish | ~i_req)) | (dcache_grant & (dcache_CacheFinish | ~d_req));
    routed = mem_data_valid & tag_valid;
    icache_MemDataValid = routed & (tag_owner == OWN_I);
    dcache_MemDataValid = routed & (tag_owner == OWN_D);
    icache_mem_read_data = icache_MemDataValid ? mem_data_out : '0;
    dcache_mem_read_data = dcache_MemDataValid ? mem_data_out : '0;
    cnt_d = cnt_q + CW'(issue) - CW'(routed);
  end

  assign protocol_err = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_owner_q <= OWN_I;
      cnt_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_q | (dcache_grant & dcache_MemRead & dcache_MemWrite) | (mem_data_valid & ~tag_valid);
      case (state_q)
        IDLE: begin
          // on a tie the cache that did not own memory last goes first
          if (d_req && !(i_req && last_owner_q == OWN_D)) state_q <= GRANT_D;
          else if (i_req) state_q <= GRANT_I;
        end
        GRANT_I, GRANT_D: begin
          if (rel) begin
            last_owner_q <= dcache_grant ? OWN_D : OWN_I;
            state_q      <= (cnt_d != '0) ? DRAIN : IDLE;
          end
        end
        default: if (cnt_d == '0) state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized cache agents and a fixed-latency memory, checked every cycle
// against a queue-based reference model of ownership and read returns.
module tb_mem_arbiter;
  import mem_arb_pkg::*;
  localparam int L = 4;

  logic        clk = 1'b0, rst = 1'b1;
  logic        icache_MemRead = 0, icache_CacheBusy = 0, icache_CacheFinish = 0;
  logic [15:0] icache_mem_addr = 0;
  logic        dcache_MemRead = 0, dcache_MemWrite = 0, dcache_CacheBusy = 0, dcache_CacheFinish = 0;
  logic [15:0] dcache_mem_addr = 0, dcache_mem_write_data = 0;
  logic        icache_grant, dcache_grant, icache_MemDataValid, dcache_MemDataValid;
  logic [15:0] icache_mem_read_data, dcache_mem_read_data;
  logic        mem_enable, mem_wr, protocol_err;
  logic [15:0] mem_addr, mem_data_in;
  logic [15:0] mem_data_out = 0;
  logic        mem_data_valid = 0;

  mem_arbiter #(.MEM_LATENCY(L)) dut (
    .clk(clk), .rst(rst),
    .icache_MemRead(icache_MemRead), .icache_mem_addr(icache_mem_addr),
    .icache_CacheBusy(icache_CacheBusy), .icache_CacheFinish(icache_CacheFinish),
    .dcache_MemRead(dcache_MemRead), .dcache_MemWrite(dcache_MemWrite),
    .dcache_mem_addr(dcache_mem_addr), .dcache_mem_write_data(dcache_mem_write_data),
    .dcache_CacheBusy(dcache_CacheBusy), .dcache_CacheFinish(dcache_CacheFinish),
    .icache_grant(icache_grant), .dcache_grant(dcache_grant),
    .icache_MemDataValid(icache_MemDataValid), .dcache_MemDataValid(dcache_MemDataValid),
    .icache_mem_read_data(icache_mem_read_data), .dcache_mem_read_data(dcache_mem_read_data),
    .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .mem_data_valid(mem_data_valid), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [15:0] data;
    logic        own;
    logic        live;
  } ent_t;

  ent_t        mq[$];
  ent_t        cur;
  bit          cur_v, m_drain, m_err, fixed_data, spur, auto_go, rst_mid, clash, gap_en;
  int          cyc, n_chk, n_pass, m_own, m_last = 1;
  int          ph[2], n[2], issued[2], got[2];
  bit          wr[2], aband[2];
  logic [15:0] base[2], seq, wdat;
  int          iv_cnt, dv_cnt, wr_cnt, drain_cnt;
  logic [15:0] w_addr, w_data;

  task automatic chk(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_chk++;
    if (got_v === exp_v) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at cycle %0d", tag, got_v, exp_v, cyc);
  endtask

  function automatic int live_cnt();
    int c;
    c = 0;
    foreach (mq[i]) if (mq[i].live) c++;
    return c;
  endfunction

  task automatic start(input int w, input int cnt, input bit is_wr, input bit ab, input logic [15:0] b);
    ph[w] = 1; n[w] = cnt; issued[w] = 0; got[w] = 0; wr[w] = is_wr; aband[w] = ab; base[w] = b;
  endtask

  task automatic model_reset();
    m_own = 0; m_drain = 0; m_last = 1; m_err = 0;
    foreach (mq[i]) mq[i].live = 1'b0;
    cur.live = 1'b0;
    ph = '{0, 0};
    clash = 0;
  endtask

  task automatic drive();
    bit g0, g1;
    cur_v = 0; mem_data_valid = 0; mem_data_out = 0;
    if (mq.size() > 0 && mq[0].due == cyc) begin
      cur = mq.pop_front(); cur_v = 1; mem_data_valid = 1; mem_data_out = cur.data;
    end else if (spur) begin
      spur = 0; mem_data_valid = 1; mem_data_out = 16'($urandom);
    end
    g0 = gap_en && $urandom_range(0, 3) == 0;
    g1 = gap_en && $urandom_range(0, 3) == 0;
    icache_CacheBusy = ph[0] != 0;
    icache_MemRead = ph[0] == 1 && !g0;
    icache_CacheFinish = ph[0] == 3;
    icache_mem_addr = base[0] + 16'(2 * issued[0]);
    dcache_CacheBusy = ph[1] != 0;
    dcache_MemWrite = ph[1] == 1 && wr[1] && !g1;
    dcache_MemRead = ph[1] == 1 && (!wr[1] || clash) && !g1;
    dcache_CacheFinish = ph[1] == 3;
    dcache_mem_addr = base[1] + 16'(2 * issued[1]);
    dcache_mem_write_data = wr[1] ? wdat : 16'h0;
  endtask

  task automatic sample();
    bit ie, de, en, wrx, routed, ir, dr, rel, g, rq, v;
    int lb, la;
    logic [15:0] dv;
    if (rst) model_reset();
    lb = live_cnt() + ((cur_v && cur.live) ? 1 : 0);
    ie = m_own == 1 && icache_MemRead;
    de = m_own == 2 && (dcache_MemRead || dcache_MemWrite);
    en = ie || de;
    wrx = m_own == 2 && dcache_MemWrite;
    routed = mem_data_valid && cur_v && cur.live;
    chk("i_grant", 32'(icache_grant), 32'(m_own == 1));
    chk("d_grant", 32'(dcache_grant), 32'(m_own == 2));
    chk("mem_enable", 32'(mem_enable), 32'(en));
    chk("mem_wr", 32'(mem_wr), 32'(wrx));
    chk("mem_addr", 32'(mem_addr), 32'(ie ? icache_mem_addr : de ? dcache_mem_addr : 16'h0));
    chk("mem_data_in", 32'(mem_data_in), 32'(wrx ? dcache_mem_write_data : 16'h0));
    chk("i_valid", 32'(icache_MemDataValid), 32'(routed && !cur.own));
    chk("d_valid", 32'(dcache_MemDataValid), 32'(routed && cur.own));
    chk("i_rdata", 32'(icache_mem_read_data), 32'((routed && !cur.own) ? cur.data : 16'h0));
    chk("d_rdata", 32'(dcache_mem_read_data), 32'((routed && cur.own) ? cur.data : 16'h0));
    chk("protocol_err", 32'(protocol_err), 32'(m_err));
    chk("inflight", 32'(dut.cnt_q), 32'(lb));
    if (icache_MemDataValid) iv_cnt++;
    if (dcache_MemDataValid) dv_cnt++;
    if (mem_wr) begin wr_cnt++; w_addr = mem_addr; w_data = mem_data_in; end
    if (dut.state_q == DRAIN) drain_cnt++;
    if (rst) return;
    if (en && !wrx) begin
      dv = fixed_data ? seq : 16'($urandom);
      seq = seq + 16'd1;
      mq.push_back('{due: cyc + L, data: dv, own: (m_own == 2), live: 1'b1});
    end
    if (m_own == 2 && dcache_MemRead && dcache_MemWrite) m_err = 1;
    if (mem_data_valid && !routed) m_err = 1;
    la = live_cnt();
    ir = icache_CacheBusy || icache_MemRead;
    dr = dcache_CacheBusy || dcache_MemRead || dcache_MemWrite;
    if (m_own == 0 && !m_drain) begin
      if (ir && dr) m_own = (m_last == 2) ? 1 : 2;
      else m_own = dr ? 2 : ir ? 1 : 0;
    end else if (m_own != 0) begin
      rel = (m_own == 1) ? (icache_CacheFinish || !ir) : (dcache_CacheFinish || !dr);
      if (rel) begin m_last = m_own; m_own = 0; m_drain = la > 0; end
    end else if (la == 0) m_drain = 0;
    for (int w = 0; w < 2; w++) begin
      g = w ? dcache_grant : icache_grant;
      rq = w ? (dcache_MemRead || dcache_MemWrite) : icache_MemRead;
      v = w ? dcache_MemDataValid : icache_MemDataValid;
      case (ph[w])
        0: if (auto_go && $urandom_range(0, 7) == 0) begin
          start(w, $urandom_range(1, 8), w == 1 && $urandom_range(0, 3) == 0,
                $urandom_range(0, 3) == 0, 16'($urandom) & 16'hfffe);
          wdat = 16'($urandom);
        end
        1: begin
          if (v && issued[w] > 0) got[w]++;
          if (g && rq) begin
            if (wr[w]) ph[w] = 3;
            else begin
              issued[w]++;
              if (issued[w] == n[w]) ph[w] = aband[w] ? 0 : 2;
            end
          end
        end
        2: begin
          if (v) got[w]++;
          if (got[w] == n[w]) ph[w] = 3;
        end
        default: ph[w] = 0;
      endcase
    end
  endtask

  task automatic cycle();
    drive();
    if (rst_mid) begin
      #2 rst = 1;
      #1;
      chk("rst_async_ctl", 32'({icache_grant, dcache_grant, icache_MemDataValid, dcache_MemDataValid,
                                mem_enable, mem_wr, protocol_err}), 32'h0);
      chk("rst_async_bus", {mem_addr, mem_data_in}, 32'h0);
      chk("rst_async_rd", {icache_mem_read_data, dcache_mem_read_data}, 32'h0);
      rst_mid = 0;
    end
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_idle(input int maxc);
    int k;
    k = 0;
    while (!(ph[0] == 0 && ph[1] == 0 && m_own == 0 && !m_drain && mq.size() == 0) && k < maxc) begin
      cycle();
      k++;
    end
    chk("idle_reached", 32'(k < maxc), 32'h1);
  endtask

  initial begin
    @(posedge clk);
    #1;
    repeat (2) cycle();
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));
    rst = 0;
    fixed_data = 1; seq = 16'd1; iv_cnt = 0; dv_cnt = 0;
    start(0, 8, 0, 0, 16'h0000);
    run_idle(100);
    chk("ifill_ivalid", 32'(iv_cnt), 32'd8);
    chk("ifill_dvalid", 32'(dv_cnt), 32'd0);
    fixed_data = 0;
    rst = 1; cycle(); rst = 0;
    start(0, 4, 0, 0, 16'h0100); start(1, 4, 0, 0, 16'h0200);
    cycle();
    chk("tie1_dgrant", 32'(dcache_grant), 32'h1);
    chk("tie1_igrant", 32'(icache_grant), 32'h0);
    run_idle(100);
    start(0, 2, 0, 0, 16'h0110); start(1, 2, 0, 0, 16'h0210);
    cycle();
    chk("tie2_dgrant", 32'(dcache_grant), 32'h1);
    run_idle(100);
    wr_cnt = 0; wdat = 16'hBEEF;
    start(1, 1, 1, 0, 16'h0040);
    run_idle(20);
    chk("wr_count", 32'(wr_cnt), 32'd1);
    chk("wr_addr", 32'(w_addr), 32'h0040);
    chk("wr_data", 32'(w_data), 32'hBEEF);
    chk("wr_notag", 32'(dut.cnt_q), 32'd0);
    drain_cnt = 0; iv_cnt = 0; dv_cnt = 0;
    start(1, 3, 0, 1, 16'h0300);
    cycle();
    start(0, 2, 0, 0, 16'h0400);
    run_idle(100);
    chk("drain_cycles", 32'(drain_cnt), 32'd3);
    chk("drain_dvalid", 32'(dv_cnt), 32'd3);
    chk("drain_ivalid", 32'(iv_cnt), 32'd2);
    clash = 1; wdat = 16'h1234;
    start(1, 1, 1, 0, 16'h0050);
    run_idle(20);
    chk("clash_err", 32'(protocol_err), 32'h1);
    clash = 0;
    start(0, 8, 0, 0, 16'h0500);
    repeat (6) cycle();
    rst_mid = 1;
    cycle();
    chk("rst_mid_state", 32'(dut.state_q), 32'(IDLE));
    chk("rst_mid_cnt", 32'(dut.cnt_q), 32'd0);
    rst = 0;
    run_idle(50);
    chk("orphan_err", 32'(protocol_err), 32'h1);
    start(0, 8, 0, 0, 16'h0600);
    repeat (5) cycle();
    rst = 1;
    repeat (L + 2) cycle();
    rst = 0;
    cycle();
    chk("rst_hold_err", 32'(protocol_err), 32'h0);
    spur = 1;
    cycle();
    chk("spur_err_set", 32'(protocol_err), 32'h1);
    repeat (5) cycle();
    chk("spur_err_sticky", 32'(protocol_err), 32'h1);
    rst = 1; cycle(); rst = 0;
    auto_go = 1; gap_en = 1;
    repeat (2000) cycle();
    auto_go = 0; gap_en = 0;
    run_idle(200);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
